// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans a 4-digit common-anode 7-segment display showing MM:SS.
// Binary minutes/seconds are latched once per frame so a digit never tears, split
// into tens/units, decoded active-low, and optionally blinked for the pair under
// adjustment. Scan and blink rates come from internal prescalers on clk.
// Optional build macro LZ_BLANK_EN: blank a minutes-tens digit of 0 (a dash is
// still shown).
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       sel,
  input  logic       adj,
  output logic [3:0] anode,
  output logic [6:0] segments
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_OFF;
    endcase
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [1:0]         digit_idx_q, digit_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               adj_q;
  logic [5:0]         min_lat_q, min_lat_d;
  logic [5:0]         sec_lat_q, sec_lat_d;
  logic [3:0]         anode_q, anode_d;
  logic [6:0]         segments_q, segments_d;

  logic       scan_wrap, frame_wrap, blink_wrap, adj_rise;
  logic [5:0] pair_val;
  logic       pair_bad;
  logic [3:0] digit;
  logic       blank;

  // Scan prescaler, digit index and once-per-frame input latch.
  always_comb begin
    scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    frame_wrap  = scan_wrap && (digit_idx_q == 2'd3);
    min_lat_d   = frame_wrap ? minutes : min_lat_q;
    sec_lat_d   = frame_wrap ? seconds : sec_lat_q;
  end

  // Blink prescaler; an adj rising edge restarts it with the digits visible.
  always_comb begin
    adj_rise   = adj && !adj_q;
    blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    if (adj_rise) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else begin
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_phase_d = blink_wrap ? !blink_phase_q : blink_phase_q;
    end
  end

  // Next anode/segment values for the current digit slot, including blanking.
  always_comb begin
    // NOTE: every output of this block gets a value before any conditional
    // override, so no path leaves a signal unassigned and no latch is inferred.
    pair_val   = digit_idx_q[1] ? min_lat_q : sec_lat_q;
    pair_bad   = (pair_val > 6'd59);
    digit      = digit_idx_q[0] ? 4'(pair_val / 6'd10) : 4'(pair_val % 6'd10);
    segments_d = pair_bad ? SEG_DASH : decode(digit);
    anode_d    = ~(4'b0001 << digit_idx_q);
    // digit_idx[1] is 1 for the minutes pair; sel=0 selects minutes.
    blank      = adj && (digit_idx_q[1] != sel) && blink_phase_d;
`ifdef LZ_BLANK_EN
    if ((digit_idx_q == 2'd3) && !pair_bad && (digit == 4'd0)) blank = 1'b1;
`else
`endif
    if (blank) begin
      anode_d    = ANODE_OFF;
      segments_d = SEG_OFF;
    end
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      adj_q         <= 1'b0;
      min_lat_q     <= 6'd0;
      sec_lat_q     <= 6'd0;
      anode_q       <= ANODE_OFF;
      segments_q    <= SEG_OFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      adj_q         <= adj;
      min_lat_q     <= min_lat_d;
      sec_lat_q     <= sec_lat_d;
      anode_q       <= anode_d;
      segments_q    <= segments_d;
    end
  end

  assign anode    = anode_q;
  assign segments = segments_q;

endmodule
